div: RTL and testbench

- Multi-cycle 32-bit integer divider for the MIPS core.
- Consumes the execute stage's divide request (start, signedness, dividend, divisor).
- Returns the 64-bit {remainder, quotient} pair and a ready flag. Execute forwards the pair to HI/LO (HI = remainder, LO = quotient).
- Execute holds the pipeline stalled while start is high and ready is low. Radix-2 shift-subtract, one quotient bit per cycle.

---
 rtl/div_pkg.sv | 33 +++
 rtl/div_step.sv | 26 ++
 rtl/div.sv | 155 +++++++++++++++
 tb/tb_div.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and helpers for the multi-cycle integer divider.
// Holds the 2-bit state codes, the ready/start flag encodings and small
// two's-complement helpers used by the divider datapath.
package div_pkg;

  localparam int WIDTH = 32;

  // Divider state codes (shared with execute/decode).
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Two's-complement negation when neg is set, identity otherwise.
  function automatic logic [WIDTH-1:0] cond_negate(input logic neg,
                                                   input logic [WIDTH-1:0] v);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Magnitude of an operand: only negative values in signed mode change.
  function automatic logic [WIDTH-1:0] magnitude(input logic is_signed,
                                                 input logic [WIDTH-1:0] v);
    return cond_negate(is_signed & v[WIDTH-1], v);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring-division step (purely combinational).
// Ports:
//   partial_i  [WIDTH:0]   {partial remainder, next dividend bit}
//   divisor_i  [WIDTH-1:0] divisor magnitude
//   rem_o      [WIDTH-1:0] new partial remainder
//   q_bit_o                quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] diff;

  // The shifted partial remainder is always below twice the divisor, so a
  // WIDTH+1-bit difference is non-negative exactly when its top bit is clear.
  assign diff    = partial_i - {1'b0, divisor_i};
  assign q_bit_o = ~diff[WIDTH];
  // When the subtract fails the partial value is below the divisor, so its
  // top bit is zero and dropping it loses nothing.
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial_i[WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle integer divider, one quotient bit per clock.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   signed_div_i    1 = signed (DIV), 0 = unsigned (DIVU)
//   opdata1_i       dividend, sampled when a request is accepted
//   opdata2_i       divisor, sampled when a request is accepted
//   start_i         request, held high until ready_o is seen
//   annul_i         abort current/pending operation (flush)
//   result_o        {remainder, quotient}, registered
//   ready_o         result valid, registered
module div
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dividend_q, dividend_d;  // shifts out dividend, shifts in quotient
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (({rem_q, dividend_q[WIDTH-1]})),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            dividend_d = magnitude(signed_div_i, opdata1_i);
            divisor_d  = magnitude(signed_div_i, opdata2_i);
            neg_quot_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
            rem_d      = '0;
            cnt_d      = '0;
          end
        end
      end

      DIV_BY_ZERO: begin
        result_d = '0;
        if (annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          ready_d = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          rem_d      = step_rem;
          dividend_d = {dividend_q[WIDTH-2:0], step_q_bit};
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          // Quotient sign follows the operand signs; remainder follows the dividend.
          result_d = {cond_negate(neg_rem_q, rem_q), cond_negate(neg_quot_q, dividend_q)};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end

      default: begin
        state_d  = DIV_FREE;
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; datapath registers are reset too so a
  // flushed or reset divider never exposes stale operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the divider: directed cases plus randomized
// requests, with expected results queued at issue time and compared by a
// separate monitor whenever ready_o rises.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
    end
  endtask

  // Reference model: plain integer division, truncating toward zero, with a
  // zero divisor giving an all-zero result.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every rising edge of ready_o must match the oldest queued result.
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (ready_o && !mon_prev) begin
      if (exp_q.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
      else check("result", result_o, exp_q.pop_front());
    end
    mon_prev = ready_o;
  end

  // Issue one division. hold keeps start high until ready; otherwise start
  // drops early and the operation must still complete. Operands are scrambled
  // while the divider is busy.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expected, input bit hold);
    int n;
    bit got;
    int lat;
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(expected);
    lat = (b == 32'd0) ? 2 : 34;
    n   = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (!hold && n == 3) start_i = 1'b0;
      if (ready_o) got = 1'b1;
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
    end
    check("latency", 64'(n), 64'(lat));
    if (got && hold) begin
      @(negedge clk);
      check("end_hold_ready", 64'(ready_o), 64'd1);
      check("end_hold_result", result_o, expected);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("release_ready", 64'(ready_o), 64'd0);
    check("release_result", result_o, 64'd0);
  endtask

  initial begin
    int n;
    int rdy_cnt;
    logic        s;
    logic [31:0] a, b;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-derived results.
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
    do_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
    do_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b1);
    do_div(1'b1, 32'd5, 32'd0, 64'd0, 1'b1);
    do_div(1'b0, 32'd5, 32'd0, 64'd0, 1'b1);

    // Annul at cnt = 10: no result may ever appear.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy_cnt++;
    end
    check("annul_no_ready", 64'(rdy_cnt), 64'd0);

    do_div(1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 1'b1);
    do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1);
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd12345;
    opdata2_i    = 32'd11;
    start_i      = 1'b1;
    exp_q.push_back(ref_div(1'b0, 32'd12345, 32'd11));
    n = 0;
    while (n < 100 && !ready_o) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_latency", 64'(n), 64'd34);
    #2 rst = 1'b1;
    #1;
    check("async_rst_end_ready", 64'(ready_o), 64'd0);
    check("async_rst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_on_ready", 64'(ready_o), 64'd0);
    check("async_rst_on_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b1);

    // Randomized requests checked against the reference model.
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = -($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      do_div(s, a, b, ref_div(s, a, b), 1'($urandom));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
